video_mode_sequencer: RTL

VIDEO_MODE_SEQUENCER -- requirements
Module: video_mode_sequencer

---
 rtl/video_mode_sequencer.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/video_mode_sequencer.sv
// video_mode_sequencer
// Brings the video output stage up after PLL lock, waits a few frames for the
// pattern generator to settle, then steps the test pattern on each debounced
// button press. The output is blanked across every pattern change, and
// re-settled afterwards.
module video_mode_sequencer #(
    parameter int unsigned C_debounce_bits  = 16,
    parameter int unsigned C_settle_frames  = 4,
    parameter logic [2:0]  C_default_switch = 3'b100
) (
    input  logic       clk_pixel,
    input  logic       resetn,
    input  logic       pll_locked,
    input  logic       btn,
    input  logic       vsync,
    output logic [2:0] switch,
    output logic       out_enable,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_SETTLE    = 2'd1,
        ST_RUN       = 2'd2,
        ST_CHANGE    = 2'd3
    } state_t;

    localparam logic [C_debounce_bits-1:0] C_db_full    = '1;
    localparam logic [C_debounce_bits-1:0] C_db_one     = C_debounce_bits'(1);
    localparam logic [3:0]                 C_last_frame = 4'(C_settle_frames - 1);

    // Synchronizer stages
    logic lock_meta_q;
    logic lock_sync_q;
    logic btn_meta_q;
    logic btn_sync_q;

    // Debounce state
    logic                       btn_prev_q;
    logic [C_debounce_bits-1:0] db_cnt_q;
    logic [C_debounce_bits-1:0] db_cnt_d;
    logic                       btn_stable_q;
    logic                       btn_stable_d;
    logic                       press;

    // Frame edge detection
    logic vsync_prev_q;
    logic vs_edge;

    // Sequencer state
    state_t     state_q;
    state_t     state_d;
    logic [3:0] frame_cnt_q;
    logic [3:0] frame_cnt_d;
    logic [2:0] switch_q;
    logic [2:0] switch_d;
    logic       out_enable_q;
    logic       out_enable_d;

    // Two-flop synchronizers for the asynchronous lock and button inputs.
    always_ff @(posedge clk_pixel or negedge resetn) begin
        if (!resetn) begin
            lock_meta_q <= 1'b0;
            lock_sync_q <= 1'b0;
            btn_meta_q  <= 1'b0;
            btn_sync_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking so each stage takes the previous stage's old
            // value; blocking here would collapse the chain into one flop.
            lock_meta_q <= pll_locked;
            lock_sync_q <= lock_meta_q;
            btn_meta_q  <= btn;
            btn_sync_q  <= btn_meta_q;
        end
    end

    // Debounce: the stable level follows the synced button only after the
    // synced button has stayed unchanged long enough to fill the counter.
    always_comb begin
        // NOTE: every signal gets its hold value first so no branch leaves it
        // unassigned and no latch is inferred.
        db_cnt_d     = db_cnt_q;
        btn_stable_d = btn_stable_q;
        press        = 1'b0;
        if (btn_sync_q != btn_prev_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == C_db_full) begin
            btn_stable_d = btn_sync_q;
            press        = btn_sync_q & ~btn_stable_q;
        end else begin
            db_cnt_d = db_cnt_q + C_db_one;
        end
    end

    // Debounce and vsync history registers.
    always_ff @(posedge clk_pixel or negedge resetn) begin
        if (!resetn) begin
            btn_prev_q   <= 1'b0;
            db_cnt_q     <= '0;
            btn_stable_q <= 1'b0;
            vsync_prev_q <= 1'b0;
        end else begin
            btn_prev_q   <= btn_sync_q;
            db_cnt_q     <= db_cnt_d;
            btn_stable_q <= btn_stable_d;
            vsync_prev_q <= vsync;
        end
    end

    assign vs_edge = vsync & ~vsync_prev_q;

    // Next-state logic: loss of lock overrides everything, otherwise each
    // state reacts only to the events it cares about and drops the rest.
    always_comb begin
        state_d      = state_q;
        frame_cnt_d  = frame_cnt_q;
        switch_d     = switch_q;
        out_enable_d = out_enable_q;
        if (!lock_sync_q) begin
            state_d      = ST_WAIT_LOCK;
            out_enable_d = 1'b0;
        end else begin
            case (state_q)
                ST_WAIT_LOCK: begin
                    out_enable_d = 1'b0;
                    state_d      = ST_SETTLE;
                    frame_cnt_d  = 4'd0;
                end
                ST_SETTLE: begin
                    if (vs_edge) begin
                        frame_cnt_d = frame_cnt_q + 4'd1;
                        if (frame_cnt_q == C_last_frame) begin
                            state_d      = ST_RUN;
                            out_enable_d = 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    out_enable_d = 1'b1;
                    if (press) begin
                        state_d = ST_CHANGE;
                    end
                end
                ST_CHANGE: begin
                    // Keep showing the old pattern until the frame boundary,
                    // then switch and blank while the generator settles.
                    if (vs_edge) begin
                        switch_d     = switch_q + 3'd1;
                        out_enable_d = 1'b0;
                        state_d      = ST_SETTLE;
                        frame_cnt_d  = 4'd0;
                    end
                end
                default: begin
                    state_d      = ST_WAIT_LOCK;
                    out_enable_d = 1'b0;
                end
            endcase
        end
    end

    // Sequencer registers; switch restarts from its default only on reset.
    always_ff @(posedge clk_pixel or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_WAIT_LOCK;
            frame_cnt_q  <= 4'd0;
            switch_q     <= C_default_switch;
            out_enable_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            frame_cnt_q  <= frame_cnt_d;
            switch_q     <= switch_d;
            out_enable_q <= out_enable_d;
        end
    end

    assign switch     = switch_q;
    assign out_enable = out_enable_q;
    assign state      = state_q;

endmodule
